mac_learn_table: RTL and testbench

MAC_LEARN_TABLE -- requirements
Module: mac_learn_table

---
 rtl/eth_switch_pkg.sv | 14 +
 rtl/mac_hash.sv | 18 +
 rtl/mac_learn_table.sv | 141 ++++++++++++++
 tb/tb_mac_learn_table.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/eth_switch_pkg.sv
// eth_switch_pkg: shared FSM states, table entry layout and MAC constants
package eth_switch_pkg;
    localparam int NUM_OF_PORTS = 256;
    localparam int PORT_W       = $clog2(NUM_OF_PORTS);
    localparam int MCAST_BIT    = 40;

    typedef enum logic [2:0] {IDLE, LEARN, LOOKUP, RESP, SWEEP} state_t;

    typedef struct packed {
        logic [47:0]       mac;
        logic [PORT_W-1:0] port;
        logic [7:0]        age;
    } entry_t;
endpackage

// File: rtl/mac_hash.sv
// mac_hash: XOR-folds a 48-bit MAC into an ADDR_WIDTH-bit table index
module mac_hash #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic [47:0]           i_mac,
    output logic [ADDR_WIDTH-1:0] o_idx
);
    localparam int NSL = (48 + ADDR_WIDTH - 1) / ADDR_WIDTH;

    logic [NSL*ADDR_WIDTH-1:0] w_ext;

    assign w_ext = (NSL*ADDR_WIDTH)'(i_mac);

    always_comb begin
        o_idx = '0;
        for (int k = 0; k < NSL; k++) o_idx ^= w_ext[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
endmodule

// File: rtl/mac_learn_table.sv
// mac_learn_table: direct-mapped MAC learning/forwarding table with aging and flush sweeps
module mac_learn_table
    import eth_switch_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int AGE_MAX    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [47:0]                  req_src_mac,
    input  logic [47:0]                  req_dst_mac,
    input  logic [$clog2(NUM_PORTS)-1:0] req_src_port,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [NUM_PORTS-1:0]         resp_port_mask,
    output logic                         resp_hit,
    input  logic                         age_tick,
    input  logic                         flush,
    output logic [15:0]                  collision_cnt
);
    localparam int PW    = $clog2(NUM_PORTS);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                r_state;
    logic [47:0]           r_src_mac;
    logic [47:0]           r_dst_mac;
    logic [PW-1:0]         r_src_port;
    logic [DEPTH-1:0]      r_valid;
    entry_t                r_tab [DEPTH];
    logic [ADDR_WIDTH-1:0] r_sweep;
    logic                  r_age_pend;
    logic                  r_flush_pend;
    logic                  r_flush_mode;
    logic [15:0]           r_coll;
    logic                  r_resp_valid;
    logic [NUM_PORTS-1:0]  r_resp_mask;
    logic                  r_resp_hit;

    logic [ADDR_WIDTH-1:0] w_sidx;
    logic [ADDR_WIDTH-1:0] w_didx;
    logic [PORT_W-1:0]     w_src_port;
    logic                  w_learn_we;
    logic                  w_coll;
    logic                  w_dst_hit;
    logic [NUM_PORTS-1:0]  w_mask_all;
    logic [NUM_PORTS-1:0]  w_mask_hit;
    logic                  w_kill;
    logic                  w_age_we;
    logic                  w_last;
    logic                  w_age_any;
    logic                  w_flush_any;
    logic                  w_start;

    mac_hash #(.ADDR_WIDTH(ADDR_WIDTH)) u_src_hash (.i_mac(r_src_mac), .o_idx(w_sidx));
    mac_hash #(.ADDR_WIDTH(ADDR_WIDTH)) u_dst_hash (.i_mac(r_dst_mac), .o_idx(w_didx));

    assign w_src_port  = PORT_W'(r_src_port);
    assign w_learn_we  = (r_state == LEARN) && !r_src_mac[MCAST_BIT];
    assign w_coll      = w_learn_we && r_valid[w_sidx] && (r_tab[w_sidx].mac != r_src_mac);
    assign w_dst_hit   = !r_dst_mac[MCAST_BIT] && r_valid[w_didx] && (r_tab[w_didx].mac == r_dst_mac);
    assign w_mask_all  = ~(NUM_PORTS'(1) << r_src_port);
    assign w_mask_hit  = (r_tab[w_didx].port == w_src_port) ? '0 : NUM_PORTS'(1) << r_tab[w_didx].port;
    assign w_kill      = r_flush_mode || (r_tab[r_sweep].age <= 8'd1);
    assign w_age_we    = (r_state == SWEEP) && r_valid[r_sweep] && !w_kill;
    assign w_last      = r_sweep == '1;
    assign w_age_any   = r_age_pend || age_tick;
    assign w_flush_any = r_flush_pend || flush;
    // a sweep may begin only where the FSM would otherwise return to IDLE
    assign w_start     = (w_age_any || w_flush_any) &&
                         ((r_state == IDLE) || (r_state == RESP && resp_ready) || (r_state == SWEEP && w_last));

    assign req_ready      = (r_state == IDLE) && !age_tick && !flush && !r_age_pend;
    assign resp_valid     = r_resp_valid;
    assign resp_port_mask = r_resp_mask;
    assign resp_hit       = r_resp_hit;
    assign collision_cnt  = r_coll;

    always_ff @(posedge clk) begin
        if (w_learn_we) r_tab[w_sidx] <= '{mac: r_src_mac, port: w_src_port, age: 8'(AGE_MAX)};
        else if (w_age_we) r_tab[r_sweep].age <= r_tab[r_sweep].age - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_sweep      <= '0;
            r_age_pend   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_flush_mode <= 1'b0;
            r_coll       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_mask  <= '0;
            r_resp_hit   <= 1'b0;
        end else begin
            if (r_state != IDLE) begin
                if (age_tick) r_age_pend <= 1'b1;
                if (flush) r_flush_pend <= 1'b1;
            end
            case (r_state)
                IDLE: if (req_valid && req_ready) begin
                    r_state    <= LEARN;
                    r_src_mac  <= req_src_mac;
                    r_dst_mac  <= req_dst_mac;
                    r_src_port <= req_src_port;
                end
                LEARN: begin
                    r_state <= LOOKUP;
                    if (w_learn_we) r_valid[w_sidx] <= 1'b1;
                    if (w_coll && r_coll != 16'hFFFF) r_coll <= r_coll + 16'd1;
                end
                LOOKUP: begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_hit   <= w_dst_hit;
                    r_resp_mask  <= w_dst_hit ? w_mask_hit : w_mask_all;
                end
                RESP: if (resp_ready) begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                end
                SWEEP: begin
                    if (w_kill) r_valid[r_sweep] <= 1'b0;
                    r_sweep <= r_sweep + 1'b1;
                    if (w_last) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_start) begin
                r_state      <= SWEEP;
                r_sweep      <= '0;
                r_flush_mode <= w_flush_any;
                r_age_pend   <= 1'b0;
                r_flush_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_learn_table.sv
// tb_mac_learn_table: scoreboard bench for the MAC learning table
module tb_mac_learn_table;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [47:0] req_src_mac = '0;
    logic [47:0] req_dst_mac = '0;
    logic [1:0]  req_src_port = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [3:0]  resp_port_mask;
    logic        resp_hit;
    logic        age_tick = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] collision_cnt;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    localparam logic [47:0] MAC_A = 48'h0011_2233_4455;
    localparam logic [47:0] MAC_B = 48'h0000_0000_0011;
    localparam logic [47:0] MAC_C = 48'h0000_0000_0022;
    localparam logic [47:0] MAC_D = 48'h0000_0000_0033;
    localparam logic [47:0] MAC_U = 48'h00AA_BBCC_DDEE;
    localparam logic [47:0] MAC_M = 48'h0100_0000_0001;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    mac_learn_table dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_src_mac(req_src_mac), .req_dst_mac(req_dst_mac), .req_src_port(req_src_port),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_port_mask(resp_port_mask),
        .resp_hit(resp_hit), .age_tick(age_tick), .flush(flush), .collision_cnt(collision_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp got mask %0h hit %0b expected none", resp_port_mask, resp_hit);
            end else begin
                chk("resp_hit", resp_hit, exp_q[0][4]);
                chk("resp_mask", resp_port_mask, exp_q[0][3:0]);
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready(input int lim);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready", req_ready, 1);
    endtask

    task automatic tick();
        wait_ready(600);
        age_tick = 1'b1;
        @(posedge clk);
        #1 age_tick = 1'b0;
    endtask

    task automatic send(input logic [47:0] s, input logic [47:0] d, input logic [1:0] p,
                        input logic h, input logic [3:0] m, input int stall = 0, input bit fl = 1'b0);
        int t = 0;
        int held = 0;
        resp_ready = (stall == 0);
        wait_ready(600);
        req_src_mac  = s;
        req_dst_mac  = d;
        req_src_port = p;
        req_valid    = 1'b1;
        exp_q.push_back({h, m});
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (stall > 0) begin
            while (!resp_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("resp_arrive", resp_valid, 1);
            flush = fl;
            repeat (stall) begin
                @(negedge clk);
                flush = 1'b0;
                if (resp_valid) held++;
            end
            chk("stall_hold", held, stall);
            @(posedge clk);
            #1 resp_ready = 1'b1;
        end
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("resp_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int bad;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mask", resp_port_mask, 0);
        chk("rst_hit", resp_hit, 0);
        chk("rst_coll", collision_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        send(MAC_A, BCAST, 2'd2, 1'b0, 4'b1011);
        send(MAC_M, MAC_A, 2'd0, 1'b1, 4'b0100);
        send(MAC_M, MAC_U, 2'd1, 1'b0, 4'b1101);
        send(MAC_M, BCAST, 2'd3, 1'b0, 4'b0111);
        send(MAC_M, MAC_A, 2'd2, 1'b1, 4'b0000, 5);

        send(MAC_B, BCAST, 2'd1, 1'b0, 4'b1101);
        chk("coll_one", collision_cnt, 1);
        send(MAC_M, MAC_A, 2'd0, 1'b0, 4'b1110);
        send(MAC_M, MAC_B, 2'd0, 1'b1, 4'b0010);

        repeat (3) tick();
        send(MAC_M, MAC_B, 2'd0, 1'b0, 4'b1110);
        send(MAC_C, BCAST, 2'd3, 1'b0, 4'b0111);
        repeat (2) tick();
        send(MAC_C, BCAST, 2'd3, 1'b0, 4'b0111);
        tick();
        send(MAC_M, MAC_C, 2'd0, 1'b1, 4'b1000);
        chk("coll_refresh", collision_cnt, 1);

        send(MAC_M, MAC_C, 2'd0, 1'b1, 4'b1000, 3, 1'b1);
        @(negedge clk);
        chk("flush_sweep_busy", req_ready, 0);
        send(MAC_M, MAC_C, 2'd0, 1'b0, 4'b1110);
        send(MAC_M, MAC_A, 2'd1, 1'b0, 4'b1101);

        send(MAC_D, BCAST, 2'd2, 1'b0, 4'b1011);
        send(MAC_M, MAC_D, 2'd0, 1'b1, 4'b0100);
        wait_ready(600);
        req_src_mac  = MAC_M;
        req_dst_mac  = MAC_D;
        req_src_port = 2'd0;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", req_ready, 1);
        chk("abort_coll", collision_cnt, 0);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) bad++;
        end
        chk("abort_no_resp", bad, 0);
        send(MAC_M, MAC_D, 2'd0, 1'b0, 4'b1110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
